// File: rtl/dmem_pipe.sv
// -----------------------------------------------------------------------------
// dmem_pipe -- parametrised data memory for the processor datapath
//
// Purpose:
//   Word-addressed on-chip storage sitting behind the MEM stage / load-store
//   logic. Requests use a valid/ready handshake (no input buffering). Reads
//   are fully pipelined and return exactly READ_LAT cycles after acceptance,
//   in order. Writes produce no response. Addresses >= DEPTH are out of range:
//   writes there are dropped, reads return zero with resp_err set. After reset
//   an optional sequencer zeroes every word before requests are accepted.
//
// Parameters:
//   DATA_W         processor-side data/address bus width
//   RAM_W          stored word width (RAM_W <= DATA_W)
//   DEPTH          number of stored words
//   READ_LAT       cycles from read acceptance to resp_valid (>= 1)
//   CLEAR_ON_RESET 1 = zero all words after reset, 0 = start running at once
//
// Configuration macro:
//   DMEM_SIGN_EXT_EN  when defined, read words are sign-extended from bit
//                     RAM_W-1 to DATA_W; otherwise they are zero-extended.
//                     Out-of-range reads always return zero.
//
// Ports:
//   clk         in   clock, all logic on rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  block accepts a request this cycle
//   req_we      in   1 = write, 0 = read
//   req_addr    in   [DATA_W] word address
//   req_wdata   in   [DATA_W] write data (upper DATA_W-RAM_W bits discarded)
//   resp_valid  out  one-cycle pulse per accepted read
//   resp_data   out  [DATA_W] read data, extended from RAM_W
//   resp_err    out  qualifies resp_valid: read address was out of range
//   init_done   out  high once the clear sequence is complete
// -----------------------------------------------------------------------------
module dmem_pipe #(
    parameter int DATA_W         = 24,
    parameter int RAM_W          = 16,
    parameter int DEPTH          = 1024,
    parameter int READ_LAT       = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              init_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Full-width copy of DEPTH so the range test sees every address bit.
    localparam logic [DATA_W:0] DEPTH_CMP = (DATA_W + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Storage, sequencer state and read pipeline
    // -------------------------------------------------------------------------
    logic [RAM_W-1:0]  mem [DEPTH];

    state_t            state_q,   state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;

    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [READ_LAT-1:0] err_q, err_d;
    logic [DATA_W-1:0]   data_q [READ_LAT];
    logic [DATA_W-1:0]   data_d [READ_LAT];

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic              in_range;
    logic [AW-1:0]     req_idx;
    logic              rd_acc;
    logic [RAM_W-1:0]  rd_word;
    logic [DATA_W-1:0] rd_ext;

    logic              mem_we;
    logic [AW-1:0]     mem_idx;
    logic [RAM_W-1:0]  mem_wdata;

    assign in_range = ({1'b0, req_addr} < DEPTH_CMP);
    assign req_idx  = req_addr[AW-1:0];
    assign rd_acc   = req_ready && req_valid && !req_we;
    assign rd_word  = mem[req_idx];

`ifdef DMEM_SIGN_EXT_EN
    logic signed [RAM_W-1:0] rd_word_s;
    assign rd_word_s = rd_word;
    // Size-casting a signed operand replicates its MSB into the new bits.
    assign rd_ext    = DATA_W'(rd_word_s);
`else
    assign rd_ext    = DATA_W'(rd_word);
`endif

    // Write-data bits above RAM_W are intentionally discarded.
    generate
        if (RAM_W < DATA_W) begin : g_wdata_upper
            logic unused_wdata_upper;
            assign unused_wdata_upper = ^req_wdata[DATA_W-1:RAM_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sequencer: next state, handshake outputs and the single write port
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        req_ready = 1'b0;
        init_done = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = req_idx;
        mem_wdata = req_wdata[RAM_W-1:0];

        case (state_q)
            S_CLEAR: begin
                // Borrow the write port to zero one word per cycle.
                mem_we    = 1'b1;
                mem_idx   = clr_cnt_q;
                mem_wdata = '0;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = S_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
                // Out-of-range writes are dropped so they cannot alias onto
                // a valid word through the truncated index.
                mem_we    = req_valid && req_we && in_range;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Nothing is accepted or written while reset is held.
        if (rst) begin
            req_ready = 1'b0;
            init_done = 1'b0;
            mem_we    = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline next-state. Each stage reloads only when the stage before
    // it carries a response, so the last stage (the outputs) holds its value
    // while resp_valid is low.
    // -------------------------------------------------------------------------
    always_comb begin
        vld_d[0]  = rd_acc;
        err_d[0]  = err_q[0];
        data_d[0] = data_q[0];
        if (rd_acc) begin
            err_d[0]  = !in_range;
            data_d[0] = in_range ? rd_ext : '0;
        end

        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i];
            data_d[i] = data_q[i];
            if (vld_q[i-1]) begin
                err_d[i]  = err_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs regardless of block order.
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_cnt_q <= '0;
            // Clearing the valid bits discards any reads still in flight.
            vld_q     <= '0;
            err_q     <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            for (int i = 0; i < READ_LAT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // NOTE: the storage array has no reset term; a reset on every word would
    // prevent RAM inference. The clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    assign resp_valid = vld_q[READ_LAT-1];
    assign resp_err   = err_q[READ_LAT-1];
    assign resp_data  = data_q[READ_LAT-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// -----------------------------------------------------------------------------
// tb_dmem_pipe -- self-checking bench for dmem_pipe (DEPTH=16, READ_LAT=2,
// CLEAR_ON_RESET=1). A word-array reference model predicts read data and the
// cycle each response must appear; a monitor records observed responses.
// -----------------------------------------------------------------------------
module tb_dmem_pipe;

    localparam int DATA_W   = 24;
    localparam int RAM_W    = 16;
    localparam int DEPTH    = 16;
    localparam int READ_LAT = 2;

    typedef struct {
        int          cyc;
        logic [23:0] data;
        logic        err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [DATA_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              init_done;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [15:0] model [DEPTH];
    bit          model_run = 0;
    rsp_t        exp_q [$];
    rsp_t        obs_q [$];

    dmem_pipe #(
        .DATA_W(DATA_W), .RAM_W(RAM_W), .DEPTH(DEPTH),
        .READ_LAT(READ_LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every response with the cycle number it was seen in.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            rsp_t r;
            r.cyc  = cyc;
            r.data = resp_data;
            r.err  = resp_err;
            obs_q.push_back(r);
        end
    end

    // Expected value of a stored word as seen on the 24-bit bus.
    function automatic logic [23:0] ext(input logic [15:0] w);
`ifdef DMEM_SIGN_EXT_EN
        return (w >= 16'h8000) ? (24'hFF0000 + 24'(w)) : 24'(w);
`else
        return 24'(w);
`endif
    endfunction

    // Present one request for one cycle (called just after a falling edge)
    // and update the model if the request is accepted.
    task automatic issue(input logic we, input int addr, input logic [23:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr[23:0];
        req_wdata = wd;
        if (model_run) begin
            if (we) begin
                if (addr < DEPTH) model[addr] = wd[15:0];
            end else begin
                rsp_t e;
                e.cyc  = cyc + READ_LAT;
                e.data = (addr < DEPTH) ? ext(model[addr]) : 24'h0;
                e.err  = (addr >= DEPTH);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_data !== 24'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 000000", resp_data); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    endtask

    task automatic test_clear;
        int n;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (req_ready === 1'b1) break;
            if (init_done !== 1'b0) begin
                errors++; checks++;
                $display("FAIL clear_init_done_early: got %b want 0 at clear cycle %0d", init_done, n);
            end
            n++;
            @(negedge clk);
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL clear_req_ready: got %b want 1", req_ready); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL clear_init_done: got %b want 1", init_done); end
        for (int a = 0; a < DEPTH; a++) model[a] = 16'h0;
        model_run = 1;
        obs_q.delete(); exp_q.delete();
        for (int a = 0; a < DEPTH; a++) issue(1'b0, a, 24'h0);
        idle(READ_LAT + 3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clear_read_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err) begin
                errors++;
                $display("FAIL clear_read[%0d]: got cyc=%0d data=%h err=%b want cyc=%0d data=%h err=%b", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].err, exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_write_readback;
        logic [23:0] want;
`ifdef DMEM_SIGN_EXT_EN
        want = 24'hFFCDEF;
`else
        want = 24'h00CDEF;
`endif
        issue(1'b1, 5, 24'hABCDEF);
        issue(1'b0, 5, 24'h0);
        idle(READ_LAT + 3);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL wr_rd_count: got %0d want 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].cyc != exp_q[0].cyc || obs_q[0].data !== want || obs_q[0].err !== 1'b0) begin
                errors++;
                $display("FAIL wr_rd_truncate: got cyc=%0d data=%h err=%b want cyc=%0d data=%h err=0",
                         obs_q[0].cyc, obs_q[0].data, obs_q[0].err, exp_q[0].cyc, want);
            end
        end
        // Outputs hold their last values while idle.
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== want || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got valid=%b data=%h err=%b want valid=0 data=%h err=0", resp_valid, resp_data, resp_err, want);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_pipelined;
        for (int a = 1; a <= 4; a++) issue(1'b1, a, 24'(a * 'h11));
        for (int a = 1; a <= 4; a++) issue(1'b0, a, 24'h0);
        idle(READ_LAT + 3);
        checks++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            errors++; $display("FAIL pipe_count: got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].data !== 24'((i + 1) * 'h11) || obs_q[i].err !== 1'b0) begin
                errors++;
                $display("FAIL pipe_read[%0d]: got cyc=%0d data=%h err=%b want cyc=%0d data=%h err=0", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].err, exp_q[i].cyc, 24'((i + 1) * 'h11));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_out_of_range;
        issue(1'b1, 20, 24'h001234);
        issue(1'b0, 20, 24'h0);
        issue(1'b0, 4, 24'h0);
        idle(READ_LAT + 3);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL oor_count: got %0d want 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].data !== 24'h0 || obs_q[0].err !== 1'b1 || obs_q[0].cyc != exp_q[0].cyc) begin
                errors++; $display("FAIL oor_read: got data=%h err=%b cyc=%0d want data=000000 err=1 cyc=%0d",
                                   obs_q[0].data, obs_q[0].err, obs_q[0].cyc, exp_q[0].cyc);
            end
            checks++;
            if (obs_q[1].data !== 24'h000044 || obs_q[1].err !== 1'b0) begin
                errors++; $display("FAIL oor_no_alias: got data=%h err=%b want data=000044 err=0", obs_q[1].data, obs_q[1].err);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 23)), 24'($urandom));
        end
        for (int a = 0; a < DEPTH; a++) issue(1'b0, a, 24'h0);
        idle(READ_LAT + 3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err) begin
                errors++;
                $display("FAIL rand_read[%0d]: got cyc=%0d data=%h err=%b want cyc=%0d data=%h err=%b", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].err, exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midflight;
        int n;
        issue(1'b0, 4, 24'h0);
        rst = 1'b1;
        req_valid = 1'b0;
        model_run = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (init_done === 1'b1) break;
            n++;
            @(negedge clk);
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL midflight_clear_cycles: got %0d want %0d", n, DEPTH); end
        idle(READ_LAT + 2);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midflight_discard: got %0d responses want 0", obs_q.size()); end
        obs_q.delete();
        for (int a = 0; a < DEPTH; a++) model[a] = 16'h0;
        model_run = 1;
        for (int a = 0; a < DEPTH; a++) issue(1'b0, a, 24'h0);
        idle(READ_LAT + 3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midflight_read_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err) begin
                errors++;
                $display("FAIL midflight_read[%0d]: got cyc=%0d data=%h err=%b want cyc=%0d data=%h err=%b", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].err, exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stall;
        bit done;
        rst = 1'b1;
        req_valid = 1'b0;
        model_run = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) issue(1'b0, 3, 24'h0);
        for (int i = 0; i < 3; i++) issue(1'b1, 3, 24'h005555);
        req_valid = 1'b0;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (init_done === 1'b1) begin done = 1; break; end
            @(negedge clk);
        end
        checks++; if (!done) begin errors++; $display("FAIL stall_timeout: init_done=%b want 1 within 40 cycles", init_done); end
        idle(READ_LAT + 2);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL stall_ignored: got %0d responses want 0", obs_q.size()); end
        obs_q.delete();
        for (int a = 0; a < DEPTH; a++) model[a] = 16'h0;
        model_run = 1;
        issue(1'b0, 3, 24'h0);
        idle(READ_LAT + 3);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL stall_readback_count: got %0d want 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].data !== 24'h0 || obs_q[0].err !== 1'b0 || obs_q[0].cyc != exp_q[0].cyc) begin
                errors++; $display("FAIL stall_write_dropped: got data=%h err=%b cyc=%0d want data=000000 err=0 cyc=%0d",
                                   obs_q[0].data, obs_q[0].err, obs_q[0].cyc, exp_q[0].cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_clear;
        test_write_readback;
        test_pipelined;
        test_out_of_range;
        test_random;
        test_reset_midflight;
        test_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_pipe.md
Name:
dmem_pipe

Overview:
- Parametrised next-generation data memory for the processor datapath.
- Generalises the fixed 24-bit-bus/16-bit-RAM data memory to configurable bus width, storage width, depth and read latency.
- Adds a valid/ready request handshake, a pipelined read response, out-of-range detection and a post-reset memory clear sequencer.
- Sits between the MEM stage / load-store logic and on-chip storage, which is an inferred RAM array inside this block.

Parameters:
DATA_W, 24, processor-side data and address bus width
RAM_W, 16, stored word width (RAM_W <= DATA_W)
DEPTH, 1024, number of stored words
READ_LAT, 2, cycles from read acceptance to resp_valid (>= 1)
CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting requests; 0 = skip

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block accepts a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  DATA_W  word address
req_wdata  in  DATA_W  write data
resp_valid  out  1  read response valid, one-cycle pulse per read
resp_data  out  DATA_W  read data, extended from RAM_W
resp_err  out  1  qualifies resp_valid: read address was out of range
init_done  out  1  high once clear sequence complete

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Acceptance: a request is accepted when req_valid && req_ready at a rising edge. There is no input buffering; requests presented while req_ready=0 are ignored.
- FSM states:
  - S_CLEAR: req_ready=0, init_done=0. A counter writes 0 to word 0..DEPTH-1, one per cycle. After word DEPTH-1 is written, go to S_RUN, so S_RUN starts DEPTH cycles after rst deasserts.
  - S_RUN: req_ready=1, init_done=1. Stays here until rst.
  - Reset entry: rst enters S_CLEAR if CLEAR_ON_RESET=1, else S_RUN. With CLEAR_ON_RESET=0, contents are undefined until written.
- Reset values: resp_valid=0, resp_data=0, resp_err=0, init_done=0, clear counter=0. req_ready=0 while rst is high.
- Reset mid-operation: all in-flight reads are discarded with no resp_valid for them. The clear restarts from word 0.
- Address range: in range iff req_addr < DEPTH. Index = req_addr[$clog2(DEPTH)-1:0].
- Write: stores req_wdata[RAM_W-1:0]; upper bits are discarded. No response is generated. An out-of-range write is dropped and has no side effect.
- Read:
  - resp_valid pulses exactly READ_LAT cycles after acceptance. Fully pipelined: one read per cycle, responses in order.
  - resp_data = word zero-extended to DATA_W.
  - Out-of-range read: resp_data=0, resp_err=1 with its resp_valid.
- Ordering: a write accepted in cycle N is visible to a read accepted in cycle N+1 or later. Only one request per cycle, so no same-cycle read/write conflict exists.
- Idle outputs: resp_data and resp_err hold their last values while resp_valid=0.
- Interleaving: reads and writes may interleave back-to-back. Writes do not stall or reorder pending read responses.

Optional Feature:
- Macro: DMEM_SIGN_EXT_EN.
- Defined: resp_data is the read word sign-extended from bit RAM_W-1 to DATA_W. Out-of-range reads still return 0.
- Undefined: zero extension, as above.
- No effect when RAM_W == DATA_W.

Test Plan:
- Clear sequence: DEPTH=16, CLEAR_ON_RESET=1, rst high 2 cycles then low -> req_ready=0 and init_done=0 for exactly 16 cycles, then both 1. Read of every address returns 0.
- Write/read-back with truncation: write addr 5 data 0xABCDEF; next cycle read addr 5 -> resp_valid exactly READ_LAT(=2) cycles later with resp_data=0x00CDEF (0xFFCDEF with DMEM_SIGN_EXT_EN). resp_err=0.
- Pipelined reads: after writing addr 1..4 with 0x0011,0x0022,0x0033,0x0044, issue reads 1,2,3,4 on 4 consecutive cycles -> 4 consecutive resp_valid pulses in order with the same data.
- Out-of-range: DEPTH=16, write addr 20 data 0x1234, then read addr 20 -> resp_valid with resp_data=0, resp_err=1. Read addr 4 still returns its prior value (0x0044).
- Reset mid-flight: issue read, assert rst the next cycle -> no resp_valid ever appears for that read; clear restarts and init_done reasserts 16 cycles after rst drops.
- Stall: req_valid=1 read addr 3 during S_CLEAR -> ignored, no response generated.
